// File: rtl/cache_controller.sv
// cache_controller: sequencing FSM for a direct-mapped cache array.
// Accepts one CPU word request at a time and splits the word address into
// tag/index/offset. On a hit it does a single array access. On a miss it
// writes back a dirty victim if needed, fetches the block from memory,
// installs it, and then replays the lookup.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cpu_*               CPU request/response interface (one outstanding request)
//   tag/index/...       latched request fields and array enables, to the array
//   hit ... done_cache  status and data returned by the array
//   mem_*               block-wide req/ack memory port (fill data goes straight
//                       from memory into the array)
module cache_controller #(
  parameter int TAG_WIDTH    = 6,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int WORD_SIZE    = 32,
  parameter int BLOCK_SIZE   = WORD_SIZE << OFFSET_WIDTH,
  parameter int ADDR_WIDTH   = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_valid,
  input  logic                    cpu_req_type,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_resp_valid,
  output logic [WORD_SIZE-1:0]    cpu_rdata,
  output logic                    cpu_err,
  output logic [TAG_WIDTH-1:0]    tag,
  output logic [INDEX_WIDTH-1:0]  index,
  output logic [OFFSET_WIDTH-1:0] blk_offset,
  output logic                    req_type,
  output logic                    read_en_cache,
  output logic                    write_en_cache,
  output logic                    refill,
  output logic [WORD_SIZE-1:0]    data_in,
  input  logic                    hit,
  input  logic                    dirty_bit,
  input  logic [TAG_WIDTH-1:0]    victim_tag,
  input  logic [WORD_SIZE-1:0]    data_out,
  input  logic [BLOCK_SIZE-1:0]   dirty_block_out,
  input  logic                    done_cache,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [BLOCK_SIZE-1:0]   mem_wdata,
  input  logic                    mem_ack
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_ACCESS, S_WB_CAPTURE,
    S_WRITEBACK, S_FILL, S_REFILL, S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]  index_q, index_d;
  logic [OFFSET_WIDTH-1:0] off_q, off_d;
  logic                    type_q, type_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [TAG_WIDTH-1:0]    vtag_q, vtag_d;
  logic [BLOCK_SIZE-1:0]   wb_buf_q, wb_buf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [WORD_SIZE-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    index_d  = index_q;
    off_d    = off_q;
    type_d   = type_q;
    wdata_d  = wdata_q;
    vtag_d   = vtag_q;
    wb_buf_d = wb_buf_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req_valid) begin
          {tag_d, index_d, off_d} = cpu_addr;
          type_d  = cpu_req_type;
          wdata_d = cpu_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          state_d = S_ACCESS;
        end else if (dirty_bit) begin
          vtag_d  = victim_tag;
          state_d = S_WB_CAPTURE;
        end else begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_ACCESS: begin
        if (done_cache) begin
          rdata_d = type_q ? '0 : data_out;
          state_d = S_RESP;
        end
      end
      S_WB_CAPTURE: begin
        // Victim block is presented by the array one cycle after read_en_cache.
        wb_buf_d = dirty_block_out;
        cnt_d    = '0;
        state_d  = S_WRITEBACK;
      end
      S_WRITEBACK, S_FILL: begin
        // An ack in the same cycle the counter would hit the limit still wins.
        if (mem_ack) begin
          cnt_d   = '0;
          state_d = (state_q == S_WRITEBACK) ? S_FILL : S_REFILL;
        end else if (cnt_inc == TMO) begin
          cnt_d   = cnt_inc;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // The line is installed at this edge; the replayed lookup now hits.
      S_REFILL: state_d = S_COMPARE;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      index_q  <= '0;
      off_q    <= '0;
      type_q   <= 1'b0;
      wdata_q  <= '0;
      vtag_q   <= '0;
      wb_buf_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      index_q  <= index_d;
      off_q    <= off_d;
      type_q   <= type_d;
      wdata_q  <= wdata_d;
      vtag_q   <= vtag_d;
      wb_buf_q <= wb_buf_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cpu_ready      = (state_q == S_IDLE);
  assign cpu_resp_valid = (state_q == S_RESP);
  assign cpu_rdata      = rdata_q;
  assign cpu_err        = err_q;

  assign tag        = tag_q;
  assign index      = index_q;
  assign blk_offset = off_q;
  assign req_type   = type_q;
  assign data_in    = wdata_q;

  // Enables decode straight from state so each is a single-cycle pulse.
  assign read_en_cache  = (state_q == S_COMPARE) && ((hit && !type_q) || (!hit && dirty_bit));
  assign write_en_cache = ((state_q == S_COMPARE) && hit && type_q) || (state_q == S_REFILL);
  assign refill         = (state_q == S_REFILL);

  // Memory port decodes from state, so reset drops mem_req immediately.
  assign mem_req   = (state_q == S_WRITEBACK) || (state_q == S_FILL);
  assign mem_we    = (state_q == S_WRITEBACK);
  assign mem_addr  = (state_q == S_WRITEBACK) ? {vtag_q, index_q, {OFFSET_WIDTH{1'b0}}} :
                     (state_q == S_FILL)      ? {tag_q,  index_q, {OFFSET_WIDTH{1'b0}}} : '0;
  assign mem_wdata = (state_q == S_WRITEBACK) ? wb_buf_q : '0;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: models the cache array and memory, then
// runs directed scenarios (miss/fill, hits, dirty write-back, timeout,
// ack at the timeout limit, async reset mid-write-back, held request).
module tb_cache_controller;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req_valid, cpu_req_type;
  logic [11:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready, cpu_resp_valid, cpu_err;
  logic [31:0]  cpu_rdata;
  logic [5:0]   tag;
  logic [3:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type, read_en_cache, write_en_cache, refill;
  logic [31:0]  data_in;
  logic         hit, dirty_bit;
  logic [5:0]   victim_tag;
  logic [31:0]  data_out;
  logic [127:0] dirty_block_out;
  logic         done_cache;
  logic         mem_req, mem_we, mem_ack;
  logic [11:0]  mem_addr;
  logic [127:0] mem_wdata;

  always #5 clk = ~clk;

  cache_controller #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .tag(tag), .index(index), .blk_offset(blk_offset), .req_type(req_type),
    .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
    .refill(refill), .data_in(data_in),
    .hit(hit), .dirty_bit(dirty_bit), .victim_tag(victim_tag),
    .data_out(data_out), .dirty_block_out(dirty_block_out),
    .done_cache(done_cache),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );

  // ---------------- array + memory model ----------------
  logic         arr_clr;
  logic         arr_valid [16];
  logic         arr_dirty [16];
  logic [5:0]   arr_tag   [16];
  logic [127:0] arr_blk   [16];
  logic [127:0] mem_blk   [1024];
  logic         mem_wr    [1024];
  logic [127:0] fill_buf;
  logic [7:0]   wait_cnt = 8'd0;
  logic [7:0]   ack_wait;

  // Untouched memory: word i of block b is 0xB10C0000 + b + i, except
  // block 0x010 (address 0x040) whose word 0 is 0xDEADBEEF.
  function automatic logic [127:0] dflt_block(input logic [9:0] blk);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = {16'hB10C, 6'd0, blk} + 32'(i);
    if (blk == 10'h010) b[31:0] = 32'hDEADBEEF;
    return b;
  endfunction

  assign hit        = arr_valid[index] && (arr_tag[index] == tag);
  assign dirty_bit  = arr_valid[index] && arr_dirty[index];
  assign victim_tag = arr_tag[index];
  assign mem_ack    = mem_req && (wait_cnt == ack_wait);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 8'd0;
    else                     wait_cnt <= wait_cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int i = 0; i < 16; i++) begin
        arr_valid[i] <= 1'b0; arr_dirty[i] <= 1'b0; arr_tag[i] <= 6'd0;
      end
      for (int j = 0; j < 1024; j++) mem_wr[j] <= 1'b0;
      done_cache <= 1'b0;
    end else begin
      done_cache <= read_en_cache | write_en_cache;
      if (read_en_cache) begin
        data_out        <= arr_blk[index][32*blk_offset +: 32];
        dirty_block_out <= arr_blk[index];
      end
      if (refill) begin
        arr_blk[index]   <= fill_buf;
        arr_valid[index] <= 1'b1;
        arr_dirty[index] <= 1'b0;
        arr_tag[index]   <= tag;
      end else if (write_en_cache) begin
        arr_blk[index][32*blk_offset +: 32] <= data_in;
        arr_dirty[index] <= 1'b1;
      end
      if (mem_req && mem_ack) begin
        if (mem_we) begin
          mem_blk[mem_addr[11:2]] <= mem_wdata;
          mem_wr[mem_addr[11:2]]  <= 1'b1;
        end else begin
          fill_buf <= mem_wr[mem_addr[11:2]] ? mem_blk[mem_addr[11:2]] : dflt_block(mem_addr[11:2]);
        end
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int           o_lat, o_req_cycles, o_first_req, o_refills;
  logic         o_wb_seen, o_fill_seen, o_err;
  logic [11:0]  o_wb_addr, o_fill_addr;
  logic [127:0] o_wb_data;
  logic [31:0]  o_rdata;

  // Issue one request and observe the transaction until cpu_resp_valid
  // (cycle 1 = first cycle after acceptance). o_lat stays 0 on a stall.
  task automatic run_req(input logic wr, input logic [11:0] addr, input logic [31:0] wd);
    o_lat = 0; o_req_cycles = 0; o_first_req = 0; o_refills = 0;
    o_wb_seen = 1'b0; o_fill_seen = 1'b0; o_wb_addr = '0; o_fill_addr = '0;
    o_wb_data = '0; o_rdata = '0; o_err = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = wr; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mem_req) begin
        o_req_cycles++;
        if (o_first_req == 0) o_first_req = cyc;
        if (mem_we) begin o_wb_seen = 1'b1; o_wb_addr = mem_addr; o_wb_data = mem_wdata; end
        else begin o_fill_seen = 1'b1; o_fill_addr = mem_addr; end
      end
      if (refill) o_refills++;
      if (cpu_resp_valid) begin
        o_lat = cyc; o_rdata = cpu_rdata; o_err = cpu_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
    n_tests++; if (cpu_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", cpu_resp_valid); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_tests++; if ({read_en_cache, write_en_cache, refill} !== 3'b000) begin n_fail++; $display("FAIL reset_enables: got %b want 000", {read_en_cache, write_en_cache, refill}); end
    n_tests++; if ({cpu_err, cpu_rdata} !== 33'd0) begin n_fail++; $display("FAIL reset_resp_regs: got %h want 0", {cpu_err, cpu_rdata}); end
    n_tests++; if ({tag, index, blk_offset, mem_addr} !== 24'd0) begin n_fail++; $display("FAIL reset_addr_outs: got %h want 0", {tag, index, blk_offset, mem_addr}); end
  endtask

  task automatic test_read_miss;
    ack_wait = 8'd0;
    run_req(1'b0, 12'h040, 32'd0);
    n_tests++; if (o_lat !== 6) begin n_fail++; $display("FAIL miss_latency: got %0d want 6", o_lat); end
    n_tests++; if (o_fill_seen !== 1'b1 || o_fill_addr !== 12'h040) begin n_fail++; $display("FAIL miss_fill_addr: got %b/%h want 1/040", o_fill_seen, o_fill_addr); end
    n_tests++; if (o_wb_seen !== 1'b0 || o_req_cycles !== 1) begin n_fail++; $display("FAIL miss_mem_cycles: got wb=%b req=%0d want wb=0 req=1", o_wb_seen, o_req_cycles); end
    n_tests++; if (o_refills !== 1) begin n_fail++; $display("FAIL miss_refill_pulses: got %0d want 1", o_refills); end
    n_tests++; if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0) begin n_fail++; $display("FAIL miss_rdata: got %h err %b want DEADBEEF err 0", o_rdata, o_err); end
  endtask

  task automatic test_write_read_hit;
    run_req(1'b1, 12'h041, 32'h12345678);
    n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL write_hit_latency: got %0d want 3", o_lat); end
    n_tests++; if (o_req_cycles !== 0 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL write_hit_mem/rdata: got req=%0d rdata=%h want 0/0", o_req_cycles, o_rdata); end
    run_req(1'b0, 12'h041, 32'd0);
    n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL read_hit_latency: got %0d want 3", o_lat); end
    n_tests++; if (o_req_cycles !== 0) begin n_fail++; $display("FAIL read_hit_mem: got %0d req cycles want 0", o_req_cycles); end
    n_tests++; if (o_rdata !== 32'h12345678) begin n_fail++; $display("FAIL read_hit_rdata: got %h want 12345678", o_rdata); end
  endtask

  task automatic test_dirty_conflict;
    ack_wait = 8'd0;
    run_req(1'b0, 12'h080, 32'd0);
    n_tests++; if (o_lat !== 8) begin n_fail++; $display("FAIL wb_latency: got %0d want 8", o_lat); end
    n_tests++; if (o_first_req !== 3) begin n_fail++; $display("FAIL wb_capture_gap: first mem_req cycle %0d want 3", o_first_req); end
    n_tests++; if (o_wb_seen !== 1'b1 || o_wb_addr !== 12'h040) begin n_fail++; $display("FAIL wb_addr: got %b/%h want 1/040", o_wb_seen, o_wb_addr); end
    n_tests++; if (o_wb_data[63:0] !== 64'h12345678_DEADBEEF) begin n_fail++; $display("FAIL wb_data: got %h want 12345678DEADBEEF", o_wb_data[63:0]); end
    n_tests++; if (o_fill_addr !== 12'h080 || o_refills !== 1) begin n_fail++; $display("FAIL wb_fill: got %h refills %0d want 080/1", o_fill_addr, o_refills); end
    n_tests++; if (o_rdata !== 32'hB10C0020) begin n_fail++; $display("FAIL wb_rdata: got %h want B10C0020", o_rdata); end
    // The written-back word must come back from memory.
    run_req(1'b0, 12'h041, 32'd0);
    n_tests++; if (o_lat !== 6 || o_wb_seen !== 1'b0) begin n_fail++; $display("FAIL refetch_path: got lat %0d wb %b want 6/0", o_lat, o_wb_seen); end
    n_tests++; if (o_rdata !== 32'h12345678) begin n_fail++; $display("FAIL refetch_rdata: got %h want 12345678", o_rdata); end
  endtask

  task automatic test_timeout;
    ack_wait = 8'hFF;
    run_req(1'b0, 12'h0C4, 32'd0);
    n_tests++; if (o_lat !== 10) begin n_fail++; $display("FAIL tmo_latency: got %0d want 10", o_lat); end
    n_tests++; if (o_req_cycles !== 8) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d want 8", o_req_cycles); end
    n_tests++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL tmo_err: got err %b rdata %h want 1/0", o_err, o_rdata); end
    n_tests++; if (o_refills !== 0) begin n_fail++; $display("FAIL tmo_refill: got %0d want 0", o_refills); end
    @(negedge clk);
    n_tests++; if (cpu_err !== 1'b1 || cpu_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_hold: got err %b ready %b req %b want 1/1/0", cpu_err, cpu_ready, mem_req); end
    ack_wait = 8'd0;
    run_req(1'b0, 12'h041, 32'd0);
    n_tests++; if (o_lat !== 3 || o_err !== 1'b0 || o_rdata !== 32'h12345678) begin n_fail++; $display("FAIL tmo_next_req: got lat %0d err %b rdata %h want 3/0/12345678", o_lat, o_err, o_rdata); end
  endtask

  task automatic test_ack_at_limit;
    ack_wait = 8'd7;  // ack in the 8th FILL cycle, same cycle the limit is reached
    run_req(1'b0, 12'h0C4, 32'd0);
    n_tests++; if (o_lat !== 13 || o_err !== 1'b0) begin n_fail++; $display("FAIL ack_limit_path: got lat %0d err %b want 13/0", o_lat, o_err); end
    n_tests++; if (o_rdata !== 32'hB10C0031 || o_refills !== 1) begin n_fail++; $display("FAIL ack_limit_data: got %h refills %0d want B10C0031/1", o_rdata, o_refills); end
  endtask

  task automatic test_reset_mid_wb;
    logic seen;
    int   resp;
    ack_wait = 8'd0;
    run_req(1'b1, 12'h0C5, 32'hCAFEF00D);
    n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL rst_setup_write: got lat %0d want 3", o_lat); end
    ack_wait = 8'hFF;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 12'h105;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_we) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rst_reach_wb: got %b want 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async: got req %b ready %b want 0/1", mem_req, cpu_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_resp_valid) resp++;
    end
    n_tests++; if (resp !== 0 || cpu_err !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_no_resp: got resp %0d err %b req %b want 0/0/0", resp, cpu_err, mem_req); end
  endtask

  task automatic test_back_to_back;
    int resp_cnt, resp1, resp2, ready_bad;
    logic rdy7, rdy8;
    logic [31:0] rd2;
    ack_wait = 8'd0;
    resp_cnt = 0; resp1 = 0; resp2 = 0; ready_bad = 0; rdy7 = 1'b0; rdy8 = 1'b1; rd2 = '0;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 12'h048;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc <= 6 && cpu_ready) ready_bad++;
      if (cyc == 7) rdy7 = cpu_ready;
      if (cyc == 8) begin rdy8 = cpu_ready; cpu_req_valid = 1'b0; end
      if (cpu_resp_valid) begin
        resp_cnt++;
        if (resp1 == 0) resp1 = cyc; else begin resp2 = cyc; rd2 = cpu_rdata; end
      end
    end
    n_tests++; if (ready_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: %0d busy cycles with ready want 0", ready_bad); end
    n_tests++; if (resp1 !== 6 || rdy7 !== 1'b1 || rdy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: resp@%0d ready7 %b ready8 %b want 6/1/0", resp1, rdy7, rdy8); end
    n_tests++; if (resp_cnt !== 2 || resp2 !== 10) begin n_fail++; $display("FAIL b2b_second: got %0d resps, second @%0d want 2/10", resp_cnt, resp2); end
    n_tests++; if (rd2 !== 32'hB10C0012) begin n_fail++; $display("FAIL b2b_rdata: got %h want B10C0012", rd2); end
  endtask

  initial begin
    rst_n = 1'b0; arr_clr = 1'b1; ack_wait = 8'd0;
    cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; arr_clr = 1'b0;
    test_reset;
    test_read_miss;
    test_write_read_hit;
    test_dirty_conflict;
    test_timeout;
    test_ack_at_limit;
    test_reset_mid_wb;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
